// File: rtl/pci_bus_arbiter_if.sv
// Arbitration signals shared by the PCI bus arbiter and the models around it.
// The master side is the arbiter, which drives the grants; the slave side drives requests and busfree.
interface pci_bus_arbiter_if;
   logic       busfree;
   logic [1:0] pci_reqn;
   logic [1:0] pci_gntn;

   modport master (
      input  busfree,
      input  pci_reqn,
      output pci_gntn
   );

   modport slave (
      output busfree,
      output pci_reqn,
      input  pci_gntn
   );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Two-master round-robin PCI arbiter with an optional park on master 0.
// Grants are registered and change only while the bus is idle.
module pci_bus_arbiter #(
   parameter logic       park    = 1'b0,
   parameter logic [4:0] timeout = 5'd16
) (
   input  logic              clk,
   input  logic              rstn,
   pci_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

   localparam logic [4:0] cnt_max = timeout - 5'd1;

   state_t     state_reg, state_next;
   logic       last_reg, last_next;
   logic       used_reg, used_next;
   logic [4:0] idle_cnt_reg, idle_cnt_next;
   logic [1:0] gntn_reg, gntn_next;
   logic [1:0] req;
   logic       pick;
   logic       own_req, other_req, release_grant;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign req[gi] = ~bus.pci_reqn[gi];
      end
   endgenerate

   // Winner is the requester that was not served last; a lone requester always wins.
   assign pick = (req[0] && req[1]) ? ~last_reg : req[1];

   assign own_req       = (state_reg == GNT1) ? req[1] : req[0];
   assign other_req     = (state_reg == GNT1) ? req[0] : req[1];
   assign release_grant = !own_req
                        || (used_reg && other_req)
                        || ((idle_cnt_reg >= cnt_max) && other_req);

   always_comb begin
      state_next    = state_reg;
      last_next     = last_reg;
      used_next     = 1'b0;
      idle_cnt_next = 5'd0;
      case (state_reg)
         IDLE: begin
            if (park && !bus.busfree) begin
               // Master 0 started a transaction on the parked grant.
               state_next = GNT0;
               last_next  = 1'b0;
            end else if (req != 2'b00) begin
               if (park && pick) begin
                  state_next = TURN;
               end else begin
                  state_next = pick ? GNT1 : GNT0;
                  last_next  = pick;
               end
            end
         end
         GNT0, GNT1: begin
            if (!bus.busfree) begin
               used_next = 1'b1;
            end else if (release_grant) begin
               state_next = TURN;
            end else begin
               used_next     = used_reg;
               idle_cnt_next = (!used_reg && (idle_cnt_reg < cnt_max))
                             ? idle_cnt_reg + 5'd1 : idle_cnt_reg;
            end
         end
         TURN: begin
            if (req != 2'b00) begin
               state_next = pick ? GNT1 : GNT0;
               last_next  = pick;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gntn_next = 2'b11;
      case (state_next)
         GNT0:    gntn_next = 2'b10;
         GNT1:    gntn_next = 2'b01;
         IDLE:    gntn_next = park ? 2'b10 : 2'b11;
         default: gntn_next = 2'b11;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_reg    <= IDLE;
         last_reg     <= 1'b1;
         used_reg     <= 1'b0;
         idle_cnt_reg <= 5'd0;
         gntn_reg     <= 2'b11;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         used_reg     <= used_next;
         idle_cnt_reg <= idle_cnt_next;
         gntn_reg     <= gntn_next;
      end
   end

   assign bus.pci_gntn = gntn_reg;
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: a vector table on an unparked instance,
// then timeout and park sequences.
module tb_pci_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   check_count = 0;
   int   pass_count  = 0;

   always #5 clk = ~clk;

   pci_bus_arbiter_if bus0 ();
   pci_bus_arbiter_if bus1 ();

   pci_bus_arbiter #(.park(1'b0), .timeout(5'd16)) u_dut0 (
      .clk  (clk),
      .rstn (rst),
      .bus  (bus0.master)
   );

   pci_bus_arbiter #(.park(1'b1), .timeout(5'd16)) u_dut1 (
      .clk  (clk),
      .rstn (rst),
      .bus  (bus1.master)
   );

   typedef struct {
      logic       rst;
      logic       bf;
      logic [1:0] reqn;
      logic [1:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic bf, input logic [1:0] rq,
                               input logic [1:0] ex, input string nm);
      vec_t v;
      v.rst  = r;
      v.bf   = bf;
      v.reqn = rq;
      v.exp  = ex;
      v.name = nm;
      vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [1:0] act, input logic [1:0] ex);
      check_count++;
      if (act === ex) pass_count++;
      else $display("FAIL %s: pci_gntn=%b expected %b", nm, act, ex);
   endtask

   task automatic step0(input logic r, input logic bf, input logic [1:0] rq,
                        input logic [1:0] ex, input string nm);
      @(negedge clk);
      rst           = r;
      bus0.busfree  = bf;
      bus0.pci_reqn = rq;
      @(posedge clk);
      #1;
      $display("[%0t] dut0 %s rst=%b busfree=%b reqn=%b gntn=%b exp=%b",
               $time, nm, r, bf, rq, bus0.pci_gntn, ex);
      check(nm, bus0.pci_gntn, ex);
   endtask

   task automatic step1(input logic r, input logic bf, input logic [1:0] rq,
                        input logic [1:0] ex, input string nm);
      @(negedge clk);
      rst           = r;
      bus1.busfree  = bf;
      bus1.pci_reqn = rq;
      @(posedge clk);
      #1;
      $display("[%0t] dut1 %s rst=%b busfree=%b reqn=%b gntn=%b exp=%b",
               $time, nm, r, bf, rq, bus1.pci_gntn, ex);
      check(nm, bus1.pci_gntn, ex);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus0.busfree  = 1'b1;
      bus0.pci_reqn = 2'b11;
      bus1.busfree  = 1'b1;
      bus1.pci_reqn = 2'b11;

      for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 2'b00, 2'b11, "reset_hold");
      add(1'b0, 1'b1, 2'b00, 2'b10, "first_grant_m0");
      for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 2'b00, 2'b10, "rr_m0_busy");
      add(1'b0, 1'b1, 2'b00, 2'b11, "rr_turn_a");
      add(1'b0, 1'b1, 2'b00, 2'b01, "rr_grant_m1");
      for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 2'b00, 2'b01, "rr_m1_busy");
      add(1'b0, 1'b1, 2'b00, 2'b11, "rr_turn_b");
      add(1'b0, 1'b1, 2'b00, 2'b10, "rr_back_m0");
      for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 2'b01, 2'b10, "hold_busy");
      add(1'b0, 1'b1, 2'b01, 2'b11, "hold_release_turn");
      add(1'b0, 1'b1, 2'b01, 2'b01, "hold_grant_m1");
      add(1'b0, 1'b1, 2'b11, 2'b11, "m1_withdraw_turn");
      add(1'b0, 1'b1, 2'b11, 2'b11, "idle_unparked_a");
      add(1'b0, 1'b1, 2'b11, 2'b11, "idle_unparked_b");
      add(1'b0, 1'b1, 2'b10, 2'b10, "single_m0");
      add(1'b0, 1'b1, 2'b11, 2'b11, "single_m0_drop");
      add(1'b0, 1'b1, 2'b11, 2'b11, "single_m0_idle");
      add(1'b0, 1'b1, 2'b01, 2'b01, "single_m1");
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 2'b01, 2'b01, "back_to_back_m1");
      add(1'b0, 1'b1, 2'b11, 2'b11, "single_m1_drop");
      add(1'b0, 1'b1, 2'b11, 2'b11, "single_m1_idle");
      add(1'b0, 1'b1, 2'b10, 2'b10, "early_drop_grant");
      add(1'b0, 1'b1, 2'b11, 2'b11, "early_drop_turn");
      add(1'b0, 1'b1, 2'b11, 2'b11, "early_drop_idle");
      add(1'b0, 1'b1, 2'b10, 2'b10, "pre_reset_grant");
      add(1'b1, 1'b1, 2'b10, 2'b11, "reset_mid_grant");
      add(1'b0, 1'b1, 2'b11, 2'b11, "post_reset_idle");
      add(1'b0, 1'b1, 2'b00, 2'b10, "post_reset_m0_first");
      add(1'b0, 1'b0, 2'b11, 2'b10, "busy_beats_release");
      add(1'b0, 1'b1, 2'b11, 2'b11, "busy_end_turn");
      add(1'b0, 1'b1, 2'b11, 2'b11, "busy_end_idle");

      foreach (vecs[i]) step0(vecs[i].rst, vecs[i].bf, vecs[i].reqn, vecs[i].exp, vecs[i].name);

      // Master 0 sits on its grant without starting while master 1 waits.
      step0(1'b0, 1'b1, 2'b10, 2'b10, "timeout_grant_m0");
      for (int i = 1; i <= 15; i++) step0(1'b0, 1'b1, 2'b00, 2'b10, "timeout_hold");
      step0(1'b0, 1'b1, 2'b00, 2'b11, "timeout_turn");
      step0(1'b0, 1'b1, 2'b00, 2'b01, "timeout_grant_m1");
      step0(1'b0, 1'b1, 2'b11, 2'b11, "timeout_cleanup_turn");
      step0(1'b0, 1'b1, 2'b11, 2'b11, "timeout_cleanup_idle");

      step1(1'b1, 1'b1, 2'b11, 2'b11, "park_reset");
      step1(1'b0, 1'b1, 2'b11, 2'b10, "park_idle");
      step1(1'b0, 1'b1, 2'b11, 2'b10, "park_idle_hold");
      step1(1'b0, 1'b1, 2'b01, 2'b11, "park_m1_turn");
      step1(1'b0, 1'b1, 2'b01, 2'b01, "park_m1_grant");
      step1(1'b0, 1'b1, 2'b11, 2'b11, "park_m1_release");
      step1(1'b0, 1'b1, 2'b11, 2'b10, "park_back");
      step1(1'b0, 1'b1, 2'b10, 2'b10, "park_m0_nogap");
      step1(1'b0, 1'b0, 2'b10, 2'b10, "park_m0_busy");
      step1(1'b0, 1'b1, 2'b11, 2'b11, "park_m0_release");
      step1(1'b0, 1'b1, 2'b11, 2'b10, "park_reparked");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central PCI bus arbiter for two masters. It samples the active-low requests and drives the active-low grants, so at most one grant is asserted at a time.
- Grants are round-robin, with an optional park on master 0. Re-arbitration happens only while the bus is idle, as reported by the bus monitor's busfree.
- Sits at the top of the PCI testbench between the master models, the DUT master port and the bus monitor.

Parameters:
- park, 1'b0: 1 parks the grant on master 0 (pci_gntn=2'b10) when nobody requests; 0 leaves all grants deasserted (2'b11).
- timeout, 16: number of consecutive idle cycles a granted master may hold the grant without starting a transaction while the other master requests. Width 5 bits, legal range 2..31.

Ports:
- clk  input  1  PCI clock; all logic is on the rising edge.
- rstn  input  1  Synchronous, active-high reset. Asserted when 1, despite the codebase port name.
- busfree  input  1  1 when the bus is idle (FRAME# and IRDY# both deasserted); from the monitor.
- pci_reqn  input  2  Active-low requests; bit 0 is master 0, bit 1 is master 1.
- pci_gntn  output  2  Active-low grants, registered; bit order matches pci_reqn.

Behaviour:
- Reset (rstn=1 at a clock edge):
  - pci_gntn=2'b11 and state=IDLE.
  - last-served pointer=1, so master 0 wins the first arbitration.
  - used flag=0 and idle counter=0.
  - Reset takes effect mid-grant or mid-transaction on the same edge.
- pci_gntn is always registered and one-hot-low or all-high. The value 2'b00 is illegal.
- States: IDLE, GNT0, GNT1, TURN.
- Arbitration pick: the requesting master that is not last-served; if only one requests, that one. Latency from request sampled to grant driven is 1 clock.
- IDLE:
  - Any request low: go to GNTx for the winner and set last-served=x.
  - No request: stay in IDLE. pci_gntn=2'b10 if park=1, else 2'b11.
  - A park grant on master 0 that is then used by master 0 behaves as GNT0. On a request from master 0 only, go to GNT0 directly with no gap.
- GNTx, each cycle:
  - used is set when busfree=0 during the grant.
  - The idle counter increments while busfree=1 and used=0; it clears when busfree=0.
  - Hold the grant while busfree=0, no matter what the requests do. A transaction in progress is never disturbed.
  - With busfree=1, release the grant (go to TURN) when:
    - reqn[x]=1 (master withdrew or finished), or
    - used=1 and the other master requests (fairness after one transaction), or
    - the idle counter reaches timeout-1 and the other master requests.
  - With busfree=1, reqn[x]=0 and the other master not requesting: keep the grant, so back-to-back transactions are allowed.
- TURN:
  - Lasts exactly 1 cycle with pci_gntn=2'b11. This gives the bus a turnaround and prevents grant overlap.
  - Then re-arbitrate as in IDLE, using the requests sampled in the TURN cycle.
  - used and the idle counter are cleared on entry to TURN.
- Simultaneous requests from idle: master 0 wins first, then the winners alternate.
- A request that drops before its grant arrives: the master is granted anyway for one cycle, then the grant is released via TURN because reqn=1.
- busfree falling in the same cycle a release condition is evaluated: hold wins (busfree=0 takes priority).
- No combinational path from inputs to pci_gntn.
- Counter wrap: the counter saturates at timeout-1.

Test Plan:
- Reset hold: rstn=1 for 5 clocks with pci_reqn=2'b00 -> pci_gntn=2'b11 throughout; one clock after rstn falls -> pci_gntn=2'b10.
- Single master: pci_reqn=2'b01 with busfree=1 -> pci_gntn=2'b01 after 1 clock. Drop the request with busfree=1 -> 2'b11 after 1 clock, and it stays 2'b11 with park=0.
- Round-robin: both request continuously; each master runs one transaction (busfree low for 4 cycles) -> grants go 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, with no 2'b00 at any time.
- Hold during busy: master 0 granted with busfree=0; master 0 deasserts its request and master 1 asserts -> pci_gntn stays 2'b10 until busfree=1, then 2'b11 for 1 cycle, then 2'b01.
- Timeout: master 0 granted, never starts (busfree=1), master 1 requesting -> master 0 grant dropped after 16 cycles, then 1 TURN cycle, then pci_gntn=2'b01.
- Park: park=1 with no requests -> pci_gntn=2'b10. A master 1 request -> 2'b11 for 1 cycle, then 2'b01. Master 0 requesting while parked -> grant stays 2'b10 with no gap.
